// File: rtl/uart_pkg.sv
// uart_pkg: shared parity modes, FSM state encodings and baud divisor helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_e;

  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + 8 * baud) / (16 * baud);
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with wrap-around pointers carrying an extra lap bit
module uart_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, rp_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign empty_o = wp_q == rp_q;
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rp_q[AW-1:0]];
  // pointer advance; a push into a full FIFO is allowed when the head leaves the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_q + (AW+1)'(do_push);
      rp_q <= rp_q + (AW+1)'(do_pop);
    end
  end
  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART, 16x oversampled receiver feeding a small FIFO
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 25000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int RX_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  input  logic                 uart_rx,
  output logic                 uart_tx
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int DW  = $clog2(DIV + 1);
  localparam int EW  = DATA_BITS + 2;

  tx_state_e tx_st_q, tx_st_d;
  logic [DW-1:0] tx_div_q, tx_div_d;
  logic [3:0] tx_tck_q, tx_tck_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic tx_par_q, tx_par_d, tx_en_q, tx_tick, tx_end;

  assign tx_ready = (tx_st_q == TX_IDLE) && tx_en_q;
  assign tx_tick  = tx_div_q == DW'(DIV - 1);
  assign tx_end   = tx_tick && (tx_tck_q == 4'd15);
  assign uart_tx  = tx_st_q == TX_START ? 1'b0 : tx_st_q == TX_DATA ? tx_sh_q[0] :
                    tx_st_q == TX_PAR ? tx_par_q : 1'b1;

  // TX next state: counters idle at zero so every frame starts a fresh bit period
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_div_d = tx_tick ? '0 : tx_div_q + 1'b1;
    tx_tck_d = tx_tck_q + {3'd0, tx_tick};
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_par_d = tx_par_q;
    case (tx_st_q)
      TX_IDLE: begin
        tx_div_d = '0;
        tx_tck_d = '0;
        if (tx_valid && tx_ready) begin
          tx_st_d  = TX_START;
          tx_sh_d  = tx_data;
          tx_par_d = (^tx_data) ^ (PARITY == PAR_ODD);
        end
      end
      TX_START: if (tx_end) begin
        tx_st_d  = TX_DATA;
        tx_bit_d = '0;
      end
      TX_DATA: if (tx_end) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'(DATA_BITS - 1)) begin
          tx_st_d  = PARITY == PAR_NONE ? TX_STOP : TX_PAR;
          tx_bit_d = '0;
        end
      end
      TX_PAR: if (tx_end) tx_st_d = TX_STOP;
      TX_STOP: if (tx_end) begin
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'(STOP_BITS - 1)) tx_st_d = TX_IDLE;
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  // TX state register; tx_en_q holds off tx_ready until the first clock after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q  <= TX_IDLE;
      tx_div_q <= '0;
      tx_tck_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
      tx_en_q  <= 1'b0;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_div_q <= tx_div_d;
      tx_tck_q <= tx_tck_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_par_q <= tx_par_d;
      tx_en_q  <= 1'b1;
    end
  end

  rx_state_e rx_st_q, rx_st_d;
  logic [DW-1:0] rx_div_q, rx_div_d;
  logic [3:0] rx_tck_q, rx_tck_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic rx_perr_q, rx_perr_d, sync1_q, sync2_q, ovr_q;
  logic rx_tick, rx_samp, rx_push, rx_pop, fifo_full, fifo_empty;
  logic [EW-1:0] fifo_out;

  assign rx_tick = rx_div_q == DW'(DIV - 1);
  assign rx_samp = rx_tick && (rx_tck_q == 4'd15);
  assign rx_pop  = rx_valid && rx_ready;
  assign rx_valid = !fifo_empty;
  assign {rx_data, rx_frame_err, rx_parity_err} = fifo_out;
  assign rx_overrun = ovr_q;

  // RX next state: tick count re-zeroed at the start mid-point so later samples land mid-bit
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_div_d  = rx_tick ? '0 : rx_div_q + 1'b1;
    rx_tck_d  = rx_tck_q + {3'd0, rx_tick};
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_perr_d = rx_perr_q;
    rx_push   = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        rx_div_d = '0;
        rx_tck_d = '0;
        if (!sync2_q) rx_st_d = RX_START;
      end
      RX_START: if (rx_tick && rx_tck_q == 4'd7) begin
        rx_tck_d  = '0;
        rx_bit_d  = '0;
        rx_perr_d = 1'b0;
        rx_st_d   = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_samp) begin
        rx_sh_d  = {sync2_q, rx_sh_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'(DATA_BITS - 1)) rx_st_d = PARITY == PAR_NONE ? RX_STOP : RX_PAR;
      end
      RX_PAR: if (rx_samp) begin
        rx_perr_d = sync2_q ^ (^rx_sh_q) ^ (PARITY == PAR_ODD);
        rx_st_d   = RX_STOP;
      end
      RX_STOP: if (rx_samp) begin
        rx_push = 1'b1;
        rx_st_d = sync2_q ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: begin
        rx_div_d = '0;
        rx_tck_d = '0;
        if (sync2_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // RX state, input synchroniser and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q   <= RX_IDLE;
      rx_div_q  <= '0;
      rx_tck_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_perr_q <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      ovr_q     <= 1'b0;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_div_q  <= rx_div_d;
      rx_tck_q  <= rx_tck_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_perr_q <= rx_perr_d;
      sync1_q   <= uart_rx;
      sync2_q   <= sync1_q;
      ovr_q     <= rx_push && fifo_full && !rx_pop;
    end
  end

  uart_fifo #(.WIDTH(EW), .DEPTH(RX_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .data_i  ({rx_sh_q, !sync2_q, rx_perr_q}),
    .pop_i   (rx_pop),
    .data_o  (fifo_out),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );
endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: randomized and directed bench with a frame-level behavioural model
module tb_uart_xcvr;
  localparam int BIT = 64;
  localparam int NB  = 12;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] tx_data = '0, rx_data;
  logic tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
  logic rx_frame_err, rx_parity_err, rx_overrun, uart_rx, uart_tx;
  logic drv = 1'b1, loop = 1'b0;

  assign uart_rx = loop ? uart_tx : drv;
  always #5 clk = ~clk;

  uart_xcvr #(
    .CLK_HZ(7372800), .BAUD(115200), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .RX_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // expected line image: start, data LSB first, even parity, two stops
  function automatic logic [NB-1:0] tx_frame(input logic [7:0] d);
    return {2'b11, ^d, d, 1'b0};
  endfunction

  logic [9:0] exp_q[$];
  logic [9:0] e;
  logic busy = 1'b0, ovr_prev = 1'b0;
  logic [NB-1:0] fr;
  int j = 0, ovr_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
      chk("rst_uart_tx", 32'(uart_tx), 32'(1));
      chk("rst_tx_ready", 32'(tx_ready), 32'(0));
      chk("rst_rx_valid", 32'(rx_valid), 32'(0));
      chk("rst_rx_overrun", 32'(rx_overrun), 32'(0));
    end else begin
      if (busy) begin
        j++;
        if (j == NB * BIT) busy = 1'b0;
      end
      chk("tx_line", 32'(uart_tx), 32'(busy ? fr[j / BIT] : 1'b1));
      chk("tx_ready", 32'(tx_ready), 32'(!busy));
      if (rx_overrun) begin
        ovr_cyc++;
        chk("overrun_width", 32'(ovr_prev), 32'(0));
      end
      ovr_prev = rx_overrun;
      if (rx_valid && exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_spurious: got entry %0h, required none", {rx_data, rx_frame_err, rx_parity_err});
      end else if (rx_valid && rx_ready) begin
        e = exp_q.pop_front();
        chk("rx_entry", 32'({rx_data, rx_frame_err, rx_parity_err}), 32'(e));
      end
      if (!busy && tx_valid && tx_ready) begin
        busy = 1'b1;
        j = -1;
        fr = tx_frame(tx_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_tx(input logic [7:0] d, input logic expect_rx);
    int n = 0;
    tick(1);
    while (!tx_ready && n < 5000) begin
      tick(1);
      n++;
    end
    chk("tx_ready_wait", 32'(tx_ready), 32'(1));
    tx_data = d;
    tx_valid = 1'b1;
    if (expect_rx) exp_q.push_back({d, 2'b00});
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic line(input logic v, input int n);
    drv = v;
    tick(n);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic bad_par, input int stop_low, input logic expect_rx);
    tick(1);
    if (expect_rx) exp_q.push_back({d, stop_low > 0, bad_par});
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(d[i], BIT);
    line((^d) ^ bad_par, BIT);
    if (stop_low > 0) line(1'b0, stop_low * BIT);
    line(1'b1, 2 * BIT);
  endtask

  task automatic drain(input string name);
    int c = 0;
    rx_ready = 1'b1;
    while (exp_q.size() != 0 && c < 20000) begin
      tick(1);
      c++;
    end
    tick(4);
    chk(name, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c, o0;
    logic td, rd;
    logic [7:0] d;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    // 0x55: start bit alone is low (bit0 is 1), whole frame is 12 bit-times
    send_tx(8'h55, 1'b0);
    n = 0;
    while (uart_tx == 1'b0 && n < 1000) begin
      tick(1);
      n++;
    end
    chk("start_bit_len", 32'(n), 32'(64));
    c = n;
    while (!tx_ready && c < 2000) begin
      tick(1);
      c++;
    end
    chk("ready_latency", 32'(c), 32'(768));
    // loopback with even parity; 0xA5 has four ones so its parity bit is 0
    loop = 1'b1;
    send_tx(8'hA5, 1'b1);
    tick(9 * BIT + 32);
    chk("parity_bit_A5", 32'(uart_tx), 32'(0));
    drain("drain_loopback");
    loop = 1'b0;
    // glitch shorter than half a bit is a false start
    rx_ready = 1'b0;
    line(1'b0, 14);
    line(1'b1, 4 * BIT);
    chk("false_start_valid", 32'(rx_valid), 32'(0));
    rx_frame(8'h96, 1'b0, 0, 1'b1);
    drain("drain_after_glitch");
    // stop held low three bit-times, then a clean frame
    rx_frame(8'h81, 1'b0, 3, 1'b1);
    rx_frame(8'h3C, 1'b0, 0, 1'b1);
    drain("drain_break");
    // overrun: four fit, fifth is dropped
    rx_ready = 1'b0;
    o0 = ovr_cyc;
    for (int i = 1; i <= 4; i++) rx_frame(8'(i), 1'b0, 0, 1'b1);
    chk("no_overrun_at_4", 32'(ovr_cyc - o0), 32'(0));
    rx_frame(8'h05, 1'b0, 0, 1'b0);
    chk("overrun_pulses", 32'(ovr_cyc - o0), 32'(1));
    chk("full_valid", 32'(rx_valid), 32'(1));
    drain("drain_overrun");
    // reset during data bit 3 of a looped-back frame
    loop = 1'b1;
    send_tx(8'hC3, 1'b0);
    tick(4 * BIT + 20);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_uart_tx", 32'(uart_tx), 32'(1));
    chk("midreset_tx_ready", 32'(tx_ready), 32'(0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    send_tx(8'h7E, 1'b1);
    drain("drain_after_reset");
    loop = 1'b0;
    // concurrent random TX and RX traffic with random rx_ready
    td = 1'b0;
    rd = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_tx(8'($urandom_range(0, 255)), 1'b0);
        td = 1'b1;
      end
      begin
        for (int i = 0; i < 12; i++) begin
          d = 8'($urandom_range(0, 255));
          rx_frame(d, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0 ? 1 : 0, 1'b1);
        end
        rd = 1'b1;
      end
      begin
        while (!(td && rd)) begin
          tick(1);
          rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain("drain_random");
    tick(2 * NB * BIT);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_xcvr.md
UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..8, meaning payload bits per frame.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0=none, 1=odd, 2=even.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2, meaning stop bits transmitted.
REQ-006 SHALL have parameter RX_DEPTH, default 4, power of two >=2, meaning RX FIFO entries.
REQ-007 SHALL have ports: clk in 1 system clock; rst_n in 1 asynchronous active-low reset.
REQ-008 SHALL have ports: tx_data in DATA_BITS byte to send; tx_valid in 1; tx_ready out 1.
REQ-009 SHALL have ports: rx_data out DATA_BITS received byte; rx_valid out 1; rx_ready in 1.
REQ-010 SHALL have ports: rx_frame_err out 1 and rx_parity_err out 1, both qualified by rx_valid; rx_overrun out 1, a one-cycle pulse.
REQ-011 SHALL have ports: uart_rx in 1 serial input (asynchronous); uart_tx out 1 serial output.

Function
REQ-012 SHALL derive the oversample divisor DIV = (CLK_HZ + 8*BAUD) / (16*BAUD) at elaboration, giving 14 at the defaults; one tick every DIV clocks; 16 ticks per bit.
REQ-013 TX FSM SHALL use states IDLE, START, DATA, PAR, STOP; PAR SHALL be skipped when PARITY=0.
REQ-014 tx_ready SHALL be 1 only in IDLE; a transfer occurs when tx_valid && tx_ready, tx_data is latched, and uart_tx SHALL drive 0 from the next cycle.
REQ-015 TX SHALL send the start bit, then data LSB-first, then the optional parity bit, then STOP_BITS high bits; each bit SHALL last exactly 16*DIV clocks, and the TX tick counter SHALL restart on acceptance.
REQ-016 The parity bit SHALL be the XOR of the data bits for even parity and its inverse for odd parity.
REQ-017 uart_rx SHALL pass through a 2-flop synchroniser; all RX decisions SHALL use the synchronised value.
REQ-018 RX FSM SHALL use states IDLE, START, DATA, PAR, STOP, BREAK; a synchronised low in IDLE SHALL enter START and zero the tick count.
REQ-019 START SHALL resample after 8 ticks; a high sample is a false start and SHALL return to IDLE with no push.
REQ-020 DATA, PAR and STOP SHALL each sample at 16-tick intervals after the start mid-point; RX SHALL check exactly one stop bit regardless of STOP_BITS.
REQ-021 At the stop sample, RX SHALL push {data, frame_err = (stop==0), parity_err} into the FIFO; parity_err SHALL be 0 when PARITY=0.
REQ-022 After a stop sample of 0, RX SHALL enter BREAK and stay there until the line is high, then go to IDLE; otherwise it SHALL go directly to IDLE.
REQ-023 FIFO output: rx_valid = not empty; rx_data and the error flags SHALL show the head entry; a pop occurs on rx_valid && rx_ready.
REQ-024 If a push and a pop occur in the same cycle while the FIFO is full, both SHALL succeed.
REQ-025 If the FIFO is full with no pop in the push cycle, the new frame SHALL be dropped, stored entries SHALL be unchanged, and rx_overrun SHALL pulse for exactly 1 cycle.
REQ-026 TX and RX SHALL be fully independent and run concurrently.

Reset
REQ-027 On rst_n low, asynchronously: uart_tx=1, tx_ready=0, rx_valid=0, rx_overrun=0, both FSMs in IDLE, FIFO empty, counters 0, synchroniser flops=1.
REQ-028 tx_ready SHALL rise on the first clock after reset release; a frame in progress when reset asserts SHALL be abandoned, with no partial push.

Structure
REQ-029 A shared package uart_pkg SHALL hold the parity-mode constants, the TX/RX state enums and the divisor function.
REQ-030 The FIFO SHALL be one sub-module, uart_fifo, parametrised by width and depth; it SHALL use wrap-around pointers with one extra bit for full/empty.

Verification
REQ-031 Defaults, send 0x55 -> uart_tx low 224 clk, then 1,0,1,0,1,0,1,0 at 224 clk each, then high; tx_ready returns after 2240 clk.
REQ-032 Loopback uart_tx->uart_rx with PARITY=2, sending 0xA5 -> rx_data=0xA5, parity bit 0, both error flags 0.
REQ-033 uart_rx low pulse of 50 clk, line otherwise idle -> no rx_valid, and RX back in IDLE.
REQ-034 Frame with stop bit forced 0 for 3 bit-times -> one entry with rx_frame_err=1, BREAK held until the line is high, next frame 0x3C received clean.
REQ-035 Five frames 0x01..0x05 with rx_ready=0 -> one rx_overrun pulse at the 5th stop sample; draining yields 0x01..0x04.
REQ-036 rst_n asserted mid-TX data bit 3 -> uart_tx=1 immediately, nothing pushed, and a new 0x7E after release transmits correctly.
